// File: rtl/div_param_if.sv
// Port bundle for div_param: start request, operands, registered results and status flags.
interface div_param_if #(
  parameter int WIDTH = 16
) ();
  logic             init_in;
  logic             sign_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             busy;
  logic             done;
  logic             DV0;

  modport master (
    output init_in, sign_in, A, B,
    input  Quotient, Remainder, busy, done, DV0
  );

  modport slave (
    input  init_in, sign_in, A, B,
    output Quotient, Remainder, busy, done, DV0
  );
endinterface

// File: rtl/div_param.sv
// Sequential restoring divider, one quotient bit per clock, WIDTH-bit quotient and remainder.
// Signed two's-complement operation is compiled in only when DIV_SIGNED_EN is defined.
module div_param #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  div_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
  logic [WIDTH-1:0] div_q, div_d;    // dividend, becomes the quotient as bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dv0_q, dv0_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // One restoring step: the shifted remainder needs WIDTH+1 bits, so the
  // trial subtraction's MSB is a true borrow.
  assign rem_sh   = {rem_q, div_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvsr_q};
  assign borrow   = trial[WIDTH];
  assign rem_next = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {div_q[WIDTH-2:0], ~borrow};

`ifdef DIV_SIGNED_EN
  logic sign_q, sign_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic a_neg;
  logic b_neg;

  assign a_neg   = sign_q & div_q[WIDTH-1];
  assign b_neg   = sign_q & dvsr_q[WIDTH-1];
  assign a_mag   = a_neg ? (~div_q + 1'b1) : div_q;
  assign b_mag   = b_neg ? (~dvsr_q + 1'b1) : dvsr_q;
  // Most-negative / -1 wraps back to most-negative here, which is the intended result.
  assign quo_fix = qneg_q ? (~quo_next + 1'b1) : quo_next;
  assign rem_fix = rneg_q ? (~rem_next + 1'b1) : rem_next;
`else
  logic unused_sign;

  assign unused_sign = bus.sign_in;
  assign a_mag       = div_q;
  assign b_mag       = dvsr_q;
  assign quo_fix     = quo_next;
  assign rem_fix     = rem_next;
`endif

  // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dv0_d   = dv0_q;
`ifdef DIV_SIGNED_EN
    sign_d  = sign_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.init_in) begin
          div_d   = bus.A;
          dvsr_d  = bus.B;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
`ifdef DIV_SIGNED_EN
          sign_d  = bus.sign_in;
`endif
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (dvsr_q == '0) begin
          dv0_d   = 1'b1;
          quo_d   = '1;
          remo_d  = div_q;
          state_d = S_DONE;
        end else begin
          dv0_d   = 1'b0;
          div_d   = a_mag;
          dvsr_d  = b_mag;
`ifdef DIV_SIGNED_EN
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
`endif
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        rem_d = rem_next;
        div_d = quo_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = quo_fix;
          remo_d  = rem_fix;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dv0_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dv0_q   <= dv0_d;
    end
  end

  // NOTE: working registers are always loaded in IDLE before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    div_q  <= div_d;
    dvsr_q <= dvsr_d;
`ifdef DIV_SIGNED_EN
    sign_q <= sign_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
`endif
  end

  assign bus.Quotient  = quo_q;
  assign bus.Remainder = remo_q;
  assign bus.DV0       = dv0_q;
  assign bus.busy      = (state_q == S_LOAD) || (state_q == S_ITER);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: doc/div_param.md
# div_param

Parametrised sequential restoring divider for the arithmetic datapath, replacing the fixed 16-bit shift/subtract divider. It computes one quotient bit per clock and returns both quotient and remainder. A registered start/done handshake, a busy flag and a divide-by-zero flag are included. Signed operation is a compile-time option; the unsigned core is always present.

## Interface
- `WIDTH`, 16, operand/result width in bits; legal range is `WIDTH >= 2`.
- `CW`, `$clog2(WIDTH+1)`, iteration counter width; derived, not overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `init_in`  in  1  start request; sampled only in IDLE.
- `sign_in`  in  1  1 = signed two's-complement operation; ignored without `DIV_SIGNED_EN`.
- `A`  in  WIDTH  dividend; captured on the start edge.
- `B`  in  WIDTH  divisor; captured on the start edge.
- `Quotient`  out  WIDTH  registered quotient.
- `Remainder`  out  WIDTH  registered remainder.
- `busy`  out  1  high in LOAD and ITER.
- `done`  out  1  one-cycle pulse in DONE.
- `DV0`  out  1  divide-by-zero flag for the last operation.

## Operation
States: IDLE, LOAD, ITER, DONE. Reset goes to IDLE.

- **IDLE**
  - `init_in=1`: capture `A`, `B` (and `sign_in`), clear the partial remainder, counter = WIDTH, go to LOAD.
  - Otherwise stay in IDLE; outputs hold their previous values.
- **LOAD**
  - Compute operand magnitudes (signed mode only) and test the captured divisor for zero.
  - Divisor == 0: set `DV0=1`, `Quotient` = all ones, `Remainder` = captured `A` (unmodified), go to DONE.
  - Otherwise clear `DV0` and go to ITER.
- **ITER**, restoring step per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial = partial remainder − divisor, computed at WIDTH+1 bits. The borrow (MSB) selects restore vs. accept.
  - Quotient bit = ~borrow, shifted into the dividend LSB.
  - Counter decrements each cycle. At counter == 1, the step completes and state goes to DONE, with `Quotient`/`Remainder` registered (sign-corrected if signed).
- **DONE**
  - `done=1` for exactly one cycle, then IDLE.
  - `init_in` in DONE is ignored and is not queued.
- Output holding:
  - `Quotient`, `Remainder` and `DV0` hold stable from DONE until the next DONE.
  - They are not cleared by a new start.
- Unsigned identity: `A = Quotient*B + Remainder`, with `Remainder < B`, for every `B != 0`.
- `init_in` while busy is ignored.

## Timing
- Let E0 be the rising edge where `init_in=1` is sampled in IDLE.
- Normal operation: LOAD after E0, ITER after E1 through E(WIDTH), DONE after E(WIDTH+1).
  - `done` is high for the cycle E0+WIDTH+1 → E0+WIDTH+2; for WIDTH=16 that is edge 17.
- Divide by zero: `done` is high for the cycle E0+1 → E0+2.
- `busy` is high from E0 until the DONE edge. `busy` and `done` are never both high.
- Back-to-back: the earliest next start is sampled at the edge ending DONE+1 (i.e., the first IDLE cycle).
- Reset values: `Quotient=0`, `Remainder=0`, `busy=0`, `done=0`, `DV0=0`, state IDLE, counter 0.
- `rst` mid-operation: abort on that edge, load all reset values, no `done` pulse. Reset has priority over `init_in` on the same edge.

## Configuration
- `DIV_SIGNED_EN` defined: `sign_in=1` selects signed division.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Quotient is negated when the operand signs differ; remainder is negated when the dividend is negative.
  - Overflow (most-negative ÷ −1): `Quotient` = most-negative, `Remainder=0`, no flag.
  - Divide by zero behaves as in unsigned mode.
- `DIV_SIGNED_EN` undefined: `sign_in` is unused and no magnitude/correction logic is synthesised. All operations are unsigned; latency is identical.

## Test plan
1. WIDTH=16 unsigned, A=1000, B=7 → `Quotient`=142, `Remainder`=6, `done` at E0+17, `busy` high for 17 cycles, `DV0=0`.
2. A=0xFFFF, B=1 → Q=0xFFFF, R=0; then A=3, B=0xFFFF → Q=0, R=3.
3. A=5, B=0 → `DV0=1`, Q=0xFFFF, R=5, `done` at E0+1; a following 9/3 → Q=3, R=0, `DV0=0`.
4. `DIV_SIGNED_EN`, `sign_in=1`:
   - A=0xFFF9 (−7), B=2 → Q=0xFFFD, R=0xFFFF.
   - A=0x8000, B=0xFFFF → Q=0x8000, R=0.
   - Same first operands with `sign_in=0` → Q=0x7FFC, R=1.
5. Start 1000/7, pulse `init_in` at E0+5 and `rst` at E0+8 → no `done`; all outputs 0 after E0+8; a new start at E0+10 yields correct results.
6. Random unsigned sweep (≥10k pairs, WIDTH=8 and WIDTH=16) → identity and `Remainder<B` hold; `done` exactly once per accepted start.
